core_mul_iter: RTL and testbench

CORE_MUL_ITER -- requirements
Module: core_mul_iter

---
 rtl/core_uarch_pkg.sv | 7 +
 rtl/core_mul_step.sv | 20 ++
 rtl/core_mul_iter.sv | 137 +++++++++++++
 tb/tb_core_mul_iter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/core_uarch_pkg.sv
// Shared core micro-architecture types.
// Word/dword typedefs and datapath constants used across core units.
package core_uarch_pkg;
  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;
  localparam int unsigned MUL_STEPS = 32;
endpackage

// File: rtl/core_mul_step.sv
// One radix-2 shift-add step of the iterative multiplier.
// The same adder doubles as the 64-bit two's-complement negator.
module core_mul_step
  import core_uarch_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [63:0] mcand,
  input  logic        mbit,
  input  logic        neg,
  output logic [63:0] sum
);
  dword_t x;
  dword_t y;

  always_comb begin
    x = neg ? ~acc : acc;
    y = (mbit && !neg) ? mcand : '0;
    sum = x + y + {63'b0, neg};
  end
endmodule

// File: rtl/core_mul_iter.sv
// Iterative 32x32 multiplier with optional 64-bit result, sign and accumulate.
// Start can arrive in any state and restarts with the new operands.
module core_mul_iter
  import core_uarch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c_hi,
  input  logic [31:0] c_lo,
  input  logic        long_mul,
  input  logic        add,
  input  logic        sig,
  output logic [31:0] q_hi,
  output logic [31:0] q_lo,
  output logic        n,
  output logic        z,
  output logic        ready
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic [4:0] cnt;
  logic       fix_ph;
  logic       neg_d;
  logic       lm;
  dword_t     acc;
  dword_t     mcand;
  word_t      mplier;
  dword_t     c_reg;

  logic       sa;
  logic       sb;
  dword_t     st_acc;
  logic       st_neg;
  logic       st_bit;
  dword_t     st_sum;
  dword_t     ac_x;
  dword_t     ac_y;
  dword_t     ac_sum;
  dword_t     res;

  assign sa = sig & long_mul & a[31];
  assign sb = sig & long_mul & b[31];

  // At start both adders are idle, so they form |a| and |b|.
  always_comb begin
    st_acc = acc;
    st_neg = 1'b0;
    st_bit = 1'b0;
    ac_x   = acc;
    ac_y   = c_reg;
    if (start) begin
      st_acc = {32'b0, a};
      st_neg = sa;
      ac_x   = {32'b0, b ^ {32{sb}}};
      ac_y   = {63'b0, sb};
    end else begin
      st_neg = (state == FIX) && !fix_ph && neg_d;
      st_bit = (state == RUN) && mplier[0];
    end
  end

  core_mul_step u_step (
    .acc   (st_acc),
    .mcand (mcand),
    .mbit  (st_bit),
    .neg   (st_neg),
    .sum   (st_sum)
  );

  assign ac_sum = ac_x + ac_y;
  assign res    = lm ? ac_sum : {32'b0, ac_sum[31:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fix_ph <= 1'b0;
      neg_d  <= 1'b0;
      lm     <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      c_reg  <= '0;
      q_hi   <= '0;
      q_lo   <= '0;
      n      <= 1'b0;
      z      <= 1'b0;
      ready  <= 1'b0;
    end else if (start) begin
      state  <= RUN;
      cnt    <= '0;
      fix_ph <= 1'b0;
      neg_d  <= sa ^ sb;
      lm     <= long_mul;
      acc    <= '0;
      mcand  <= {32'b0, st_sum[31:0]};
      mplier <= ac_sum[31:0];
      c_reg  <= !add ? '0 :
                long_mul ? {c_hi, c_lo} : {32'b0, c_lo};
      ready  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          acc    <= st_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(MUL_STEPS - 1)) begin
            state  <= FIX;
            fix_ph <= 1'b0;
          end
        end
        FIX: begin
          if (!fix_ph) begin
            if (neg_d) acc <= st_sum;
            fix_ph <= 1'b1;
          end else begin
            q_hi  <= res[63:32];
            q_lo  <= res[31:0];
            n     <= lm ? res[63] : res[31];
            z     <= (res == '0);
            ready <= 1'b1;
            state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_core_mul_iter.sv
// Directed self-checking bench for core_mul_iter.
// Vectors carry hand-computed results, latencies and reset behaviour.
module tb_core_mul_iter;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c_hi;
  logic [31:0] c_lo;
  logic        long_mul;
  logic        add;
  logic        sig;
  logic [31:0] q_hi;
  logic [31:0] q_lo;
  logic        n;
  logic        z;
  logic        ready;

  int checks = 0;
  int errors = 0;

  core_mul_iter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_hi     (c_hi),
    .c_lo     (c_lo),
    .long_mul (long_mul),
    .add      (add),
    .sig      (sig),
    .q_hi     (q_hi),
    .q_lo     (q_lo),
    .n        (n),
    .z        (z),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ich, input logic [31:0] icl,
                       input logic il, input logic iad, input logic isg);
    @(negedge clk);
    a = ia; b = ib; c_hi = ich; c_lo = icl;
    long_mul = il; add = iad; sig = isg;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges after the start edge until ready rises; 0 if never within bound.
  task automatic wait_ready(output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic op(input string tag,
                    input logic [31:0] ia, input logic [31:0] ib,
                    input logic [31:0] ich, input logic [31:0] icl,
                    input logic il, input logic iad, input logic isg,
                    input logic [63:0] eq, input logic en, input logic ez);
    int lat;
    issue(ia, ib, ich, icl, il, iad, isg);
    wait_ready(lat);
    check({tag, " lat"}, 64'(lat), 64'd34);
    check({tag, " q"}, {q_hi, q_lo}, eq);
    check({tag, " n"}, {63'b0, n}, {63'b0, en});
    check({tag, " z"}, {63'b0, z}, {63'b0, ez});
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; c_hi = '0; c_lo = '0;
    long_mul = 1'b0; add = 1'b0; sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {63'b0, ready}, 64'd0);
    check("rst q", {q_hi, q_lo}, 64'd0);
    check("rst nz", {62'b0, n, z}, 64'd0);
    @(negedge clk) rst = 1'b0;

    op("u32", 32'd7, 32'd6, 0, 0, 0, 0, 0, 64'd42, 0, 0);
    op("slong", 32'hFFFF_FFFF, 32'd2, 0, 0, 1, 0, 1,
       64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    op("ulong", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0, 0,
       64'hFFFF_FFFE_0000_0001, 1, 0);
    op("accwrap", 32'h8000_0000, 32'd2, 0, 32'd5, 0, 1, 0, 64'd5, 0, 0);
    op("zero", 32'd0, 32'd123, 0, 0, 0, 0, 0, 64'd0, 0, 1);
    op("smlal", 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd20, 1, 1, 1,
       64'd5, 0, 0);
    op("umlal", 32'h0001_0000, 32'h0001_0000, 32'h1, 32'hFFFF_FFFF,
       1, 1, 0, 64'h0000_0002_FFFF_FFFF, 0, 0);
    op("mla32", 32'hFFFF_FFFF, 32'd3, 32'hDEAD_BEEF, 32'd1, 0, 1, 1,
       64'hFFFF_FFFE, 1, 0);

    repeat (5) @(posedge clk);
    #1;
    check("hold ready", {63'b0, ready}, 64'd1);
    check("hold q", {q_hi, q_lo}, 64'h0000_0000_FFFF_FFFE);

    // Restart at edge 10 of a running operation.
    issue(32'd3, 32'd3, 0, 0, 0, 0, 0);
    check("restart drop", {63'b0, ready}, 64'd0);
    seen = 0;
    repeat (9) begin
      @(posedge clk);
      #1 if (ready) seen++;
    end
    issue(32'd4, 32'd5, 0, 0, 0, 0, 0);
    wait_ready(lat);
    check("restart early", 64'(seen), 64'd0);
    check("restart lat", 64'(lat), 64'd34);
    check("restart q", {q_hi, q_lo}, 64'd20);

    // Reset in the middle of an operation.
    issue(32'd9, 32'd9, 0, 0, 0, 0, 0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst ready", {63'b0, ready}, 64'd0);
    check("midrst q", {q_hi, q_lo}, 64'd0);
    check("midrst nz", {62'b0, n, z}, 64'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ready) seen++;
    end
    check("midrst noready", 64'(seen), 64'd0);

    op("post", 32'd11, 32'd13, 0, 0, 0, 0, 0, 64'd143, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
